// File: rtl/execution_monitor.sv
// Execution monitor: counts retired instructions, records a trace of {pc, instruction}
// in a circular FIFO, and halts on self-jump loops, an instruction limit or illegal opcodes.
// Host access goes through a small word-addressed register window.
module execution_monitor #(
    parameter int unsigned TRACE_DEPTH                = 16,
    parameter int unsigned LOOP_THRESHOLD             = 4,
    parameter int unsigned INSTRUCTION_LIMIT          = 0,
    parameter bit          ALLOW_ILLEGAL_INSTRUCTIONS = 1'b1
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_retire,
    input  logic [31:0] i_pc_current,
    input  logic [31:0] i_pc_next,
    input  logic [31:0] i_instruction,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [1:0]  i_address,
    output logic [31:0] o_data_out,
    output logic        o_halt
);

    localparam int unsigned AW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

    typedef enum logic [0:0] {StRun, StHalted} state_e;

    state_e        r_state;
    state_e        w_state_next;
    logic [1:0]    r_cause;
    logic [1:0]    w_cause_next;
    logic [31:0]   r_retire_count;
    logic [15:0]   r_loop_count;
    logic [15:0]   w_loop_inc;
    logic          r_overflow;
    logic [31:0]   r_data_out;

    logic [31:0]   r_mem_pc  [TRACE_DEPTH];
    logic [31:0]   r_mem_ins [TRACE_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_clear;
    logic          w_clear_count;
    logic          w_ret;
    logic          w_self_jump;
    logic          w_loop_hit;
    logic          w_limit_hit;
    logic          w_opcode_legal;
    logic          w_illegal;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_status;
    logic [31:0]   w_rdata;

    assign w_clear       = i_write && (i_address == 2'd0);
    assign w_clear_count = i_write && (i_address == 2'd1);
    // A control clear in the same cycle swallows the retire.
    assign w_ret         = i_retire && (r_state == StRun) && !w_clear && !i_reset;

    assign w_self_jump   = (i_pc_current == i_pc_next);
    assign w_loop_inc    = r_loop_count + 16'd1;
    assign w_loop_hit    = w_self_jump && (w_loop_inc == 16'(LOOP_THRESHOLD));
    assign w_limit_hit   = (INSTRUCTION_LIMIT != 0) &&
                           ((r_retire_count + 32'd1) == 32'(INSTRUCTION_LIMIT));

    // Decode the set of recognised base opcodes.
    always_comb begin
        w_opcode_legal = 1'b0;
        case (i_instruction[6:0])
            7'h03, 7'h07, 7'h13, 7'h17, 7'h23, 7'h2F, 7'h33,
            7'h37, 7'h53, 7'h63, 7'h67, 7'h6F, 7'h73: w_opcode_legal = 1'b1;
            default:                                   w_opcode_legal = 1'b0;
        endcase
    end

    assign w_illegal = !ALLOW_ILLEGAL_INSTRUCTIONS && !w_opcode_legal;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW + 1)'(TRACE_DEPTH));
    assign w_push  = w_ret;
    assign w_pop   = i_read && (i_address == 2'd3) && !w_empty && !i_reset;

    // Next state and halt cause; illegal outranks loop, loop outranks limit.
    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_cause;
        if (w_clear) begin
            w_state_next = StRun;
            w_cause_next = 2'd0;
        end else if (w_ret && (w_illegal || w_loop_hit || w_limit_hit)) begin
            w_state_next = StHalted;
            if (w_illegal) begin
                w_cause_next = 2'd3;
            end else if (w_loop_hit) begin
                w_cause_next = 2'd1;
            end else begin
                w_cause_next = 2'd2;
            end
        end
    end

    // FSM state and cause register.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= StRun;
            r_cause <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
        end
    end

    // Retire counter and consecutive self-jump counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_retire_count <= 32'd0;
            r_loop_count   <= 16'd0;
        end else begin
            if (w_clear_count) begin
                r_retire_count <= 32'd0;
            end else if (w_ret) begin
                r_retire_count <= r_retire_count + 32'd1;
            end
            if (w_clear) begin
                r_loop_count <= 16'd0;
            end else if (w_ret) begin
                r_loop_count <= w_self_jump ? w_loop_inc : 16'd0;
            end
        end
    end

    // Trace storage; no reset needed since the pointers gate visibility.
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem_pc[r_wptr]  <= i_pc_current;
            r_mem_ins[r_wptr] <= i_instruction;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; a push into a full FIFO drops the oldest.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop || (w_push && w_full)) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_pop && !w_full) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW + 1)'(1);
            end
            if (w_clear) begin
                r_overflow <= 1'b0;
            end else if (w_push && !w_pop && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_status = {16'(r_count), 10'd0, w_full, w_empty, r_overflow, r_cause,
                       (r_state == StHalted)};

    // Register read mux, sourced from pre-update state.
    always_comb begin
        w_rdata = 32'd0;
        case (i_address)
            2'd0:    w_rdata = w_status;
            2'd1:    w_rdata = r_retire_count;
            2'd2:    w_rdata = w_empty ? 32'd0 : r_mem_pc[r_rptr];
            default: w_rdata = w_empty ? 32'd0 : r_mem_ins[r_rptr];
        endcase
    end

    // Registered read data, held when no read is issued.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_data_out <= 32'd0;
        end else if (i_read) begin
            r_data_out <= w_rdata;
        end
    end

    assign o_data_out = r_data_out;
    assign o_halt     = (r_state == StHalted);

endmodule

// File: tb/tb_execution_monitor.sv
// Directed self-checking bench for execution_monitor. Instance A covers loop, limit,
// illegal and control behaviour; instance B (4-entry trace) covers FIFO overflow.
module tb_execution_monitor;

    logic        clk;
    logic        rst;
    logic        retire;
    logic [31:0] pc_cur;
    logic [31:0] pc_nxt;
    logic [31:0] ins;
    logic        rd;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] dout_a;
    logic [31:0] dout_b;
    logic        halt_a;
    logic        halt_b;

    int n_tests;
    int n_fail;

    execution_monitor #(
        .TRACE_DEPTH               (16),
        .LOOP_THRESHOLD            (4),
        .INSTRUCTION_LIMIT         (10),
        .ALLOW_ILLEGAL_INSTRUCTIONS(1'b0)
    ) dut_a (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_retire     (retire),
        .i_pc_current (pc_cur),
        .i_pc_next    (pc_nxt),
        .i_instruction(ins),
        .i_read       (rd),
        .i_write      (wr),
        .i_address    (addr),
        .o_data_out   (dout_a),
        .o_halt       (halt_a)
    );

    execution_monitor #(
        .TRACE_DEPTH               (4),
        .LOOP_THRESHOLD            (4),
        .INSTRUCTION_LIMIT         (0),
        .ALLOW_ILLEGAL_INSTRUCTIONS(1'b1)
    ) dut_b (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_retire     (retire),
        .i_pc_current (pc_cur),
        .i_pc_next    (pc_nxt),
        .i_instruction(ins),
        .i_read       (rd),
        .i_write      (wr),
        .i_address    (addr),
        .o_data_out   (dout_b),
        .o_halt       (halt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic do_retire(input logic [31:0] pc, input logic [31:0] npc,
                             input logic [31:0] op);
        retire = 1'b1;
        pc_cur = pc;
        pc_nxt = npc;
        ins    = op;
        tick();
        retire = 1'b0;
    endtask

    task automatic do_read(input logic [1:0] a);
        rd   = 1'b1;
        addr = a;
        tick();
        rd   = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] a);
        wr   = 1'b1;
        addr = a;
        tick();
        wr   = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        retire  = 1'b0;
        pc_cur  = '0;
        pc_nxt  = '0;
        ins     = 32'h13;
        rd      = 1'b0;
        wr      = 1'b0;
        addr    = 2'd0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_halt", {31'd0, halt_a}, 32'd0);
        check("rst_dout", dout_a, 32'd0);
        do_read(2'd0);
        check("rst_status", dout_a, 32'h0000_0010);

        // Loop halt after four self-jumps
        for (int i = 0; i < 3; i++) do_retire(32'h40, 32'h40, 32'h13);
        check("loop_halt_early", {31'd0, halt_a}, 32'd0);
        do_retire(32'h40, 32'h40, 32'h13);
        check("loop_halt", {31'd0, halt_a}, 32'd1);
        do_read(2'd0);
        check("loop_status", dout_a, 32'h0004_0003);
        do_read(2'd1);
        check("loop_count", dout_a, 32'd4);
        do_read(2'd2);
        check("loop_head_pc", dout_a, 32'h40);

        // Clear while halted with a coincident retire
        wr     = 1'b1;
        addr   = 2'd0;
        do_retire(32'h80, 32'h84, 32'h13);
        wr     = 1'b0;
        check("clr_halt", {31'd0, halt_a}, 32'd0);
        do_read(2'd1);
        check("clr_count", dout_a, 32'd4);
        do_read(2'd0);
        check("clr_status", dout_a, 32'h0004_0000);
        do_read(2'd3);
        check("pop_ins", dout_a, 32'h13);
        do_read(2'd0);
        check("pop_status", dout_a, 32'h0003_0000);

        // Reset while halted with three entries
        do_reset();
        do_retire(32'h100, 32'h104, 32'h13);
        do_retire(32'h104, 32'h108, 32'h13);
        do_retire(32'h108, 32'h10C, 32'h7F);
        check("ill_halt", {31'd0, halt_a}, 32'd1);
        do_read(2'd0);
        check("ill_status", dout_a, 32'h0003_0007);
        do_reset();
        check("rst2_halt", {31'd0, halt_a}, 32'd0);
        check("rst2_dout", dout_a, 32'd0);
        do_read(2'd0);
        check("rst2_status", dout_a, 32'h0000_0010);

        // Instruction limit
        do_reset();
        for (int i = 0; i < 9; i++) do_retire(32'(i * 4), 32'(i * 4 + 4), 32'h13);
        check("lim_halt_early", {31'd0, halt_a}, 32'd0);
        do_retire(32'd36, 32'd40, 32'h13);
        check("lim_halt", {31'd0, halt_a}, 32'd1);
        do_read(2'd0);
        check("lim_status", dout_a, 32'h000A_0005);
        do_retire(32'd40, 32'd44, 32'h13);
        do_read(2'd1);
        check("lim_count", dout_a, 32'd10);

        // Illegal outranks loop
        do_reset();
        for (int i = 0; i < 3; i++) do_retire(32'h200, 32'h200, 32'h13);
        do_retire(32'h200, 32'h200, 32'h7F);
        do_read(2'd0);
        check("prio_ill_status", dout_a, 32'h0004_0007);

        // Loop outranks limit
        do_reset();
        for (int i = 0; i < 6; i++) do_retire(32'(i * 4), 32'(i * 4 + 4), 32'h13);
        for (int i = 0; i < 4; i++) do_retire(32'h300, 32'h300, 32'h13);
        do_read(2'd0);
        check("prio_loop_status", dout_a, 32'h000A_0003);

        // Read and clear together return the pre-clear status
        rd   = 1'b1;
        wr   = 1'b1;
        addr = 2'd0;
        tick();
        rd   = 1'b0;
        wr   = 1'b0;
        check("rw_dout", dout_a, 32'h000A_0003);
        check("rw_halt", {31'd0, halt_a}, 32'd0);
        do_write(2'd1);
        do_read(2'd1);
        check("cnt_clear", dout_a, 32'd0);
        do_read(2'd0);
        check("cnt_clear_status", dout_a, 32'h000A_0000);

        // Empty reads
        do_reset();
        do_read(2'd3);
        check("empty_pop", dout_a, 32'd0);
        do_read(2'd0);
        check("empty_status", dout_a, 32'h0000_0010);

        // Overflow on the 4-entry instance
        do_reset();
        for (int i = 0; i < 6; i++) do_retire(32'(i * 4), 32'(i * 4 + 4), 32'((i * 4) << 8) | 32'h13);
        do_read(2'd0);
        check("ovf_status", dout_b, 32'h0004_0028);
        do_read(2'd2);
        check("ovf_head_pc", dout_b, 32'h8);
        rd   = 1'b1;
        addr = 2'd3;
        do_retire(32'h18, 32'h1C, 32'h1813);
        rd   = 1'b0;
        check("pushpop_ins", dout_b, 32'h0813);
        do_read(2'd0);
        check("pushpop_status", dout_b, 32'h0004_0028);
        do_read(2'd2);
        check("pushpop_head_pc", dout_b, 32'hC);
        do_write(2'd0);
        do_read(2'd0);
        check("ovf_clear_status", dout_b, 32'h0004_0020);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/execution_monitor.md
EXECUTION_MONITOR -- requirements
Module: execution_monitor

Interface
REQ-001 Parameter TRACE_DEPTH, default 16, trace FIFO entries; power of two, 2..256.
REQ-002 Parameter LOOP_THRESHOLD, default 4, consecutive self-jump retires that trigger a loop halt; 1..65535.
REQ-003 Parameter INSTRUCTION_LIMIT, default 0, retires before a limit halt; 0 disables.
REQ-004 Parameter ALLOW_ILLEGAL_INSTRUCTIONS, default 1; 0 enables illegal-opcode halt.
REQ-005 clock  in  1  sole clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 retire  in  1  one-cycle pulse per retired instruction.
REQ-008 pc_current  in  32  PC of the retiring instruction.
REQ-009 pc_next  in  32  PC following the retiring instruction.
REQ-010 instruction  in  32  encoding of the retiring instruction.
REQ-011 read  in  1  register read strobe.
REQ-012 write  in  1  register write strobe (control).
REQ-013 address  in  2  word register select.
REQ-014 data_out  out  32  registered read data.
REQ-015 halt  out  1  high while state is HALTED.

Function
REQ-016 FSM states RUN, HALTED; halt = (state == HALTED), no other decode.
REQ-017 In RUN, retire increments the 32-bit retire_count (wraps 0xFFFFFFFF -> 0) and pushes {pc_current, instruction} into the trace FIFO.
REQ-018 In HALTED, retire is ignored: no count, no push, no loop update.
REQ-019 Loop counter (16 bit): retire with pc_current == pc_next increments it, retire otherwise clears it; no retire holds it.
REQ-020 Loop halt when a retire makes the loop counter equal LOOP_THRESHOLD: cause = 1.
REQ-021 Limit halt when a retire makes retire_count equal INSTRUCTION_LIMIT (non-zero): cause = 2.
REQ-022 Illegal halt when ALLOW_ILLEGAL_INSTRUCTIONS = 0 and retiring instruction[6:0] not in {03,07,13,17,23,2F,33,37,53,63,67,6F,73} hex: cause = 3.
REQ-023 Halt-causing retire is itself counted and traced; HALTED entered the next edge; halt high from the following cycle.
REQ-024 Simultaneous causes: priority illegal (3) > loop (1) > limit (2); only one cause recorded.
REQ-025 Push while FIFO full discards the oldest entry, keeps the new one, sets sticky overflow.
REQ-026 Register map (address): 0 status; 1 retire_count; 2 head PC (no pop); 3 head instruction, pops head.
REQ-027 Status word: [0] halted, [2:1] cause, [3] overflow, [4] empty, [5] full, [15:6] 0, [31:16] entry count.
REQ-028 data_out updated on the edge where read is high, one-cycle latency, held otherwise.
REQ-029 Reads of address 2 or 3 while empty return 0; address 3 read on empty does not pop.
REQ-030 Push and pop same cycle: both occur, count unchanged; when full, no overflow set, no entry discarded beyond the popped one.
REQ-031 Read data reflects state before the same-edge update (pop/push/count).
REQ-032 write to address 0 (data ignored): state -> RUN, cause, loop counter, overflow cleared; FIFO and retire_count kept.
REQ-033 write to address 1: retire_count cleared; writes to 2, 3 ignored.
REQ-034 write to address 0 coincident with retire: clear wins, retire ignored that cycle.
REQ-035 read and write same cycle: both serviced, read returns pre-write value.

Reset
REQ-036 reset high at an edge: state RUN, halt 0, data_out 0, retire_count 0, loop counter 0, cause 0, overflow 0, FIFO empty (pointers 0).
REQ-037 reset dominates all inputs in the same cycle, including mid-halt and mid-read; no retire counted or traced.

Verification
REQ-038 LOOP_THRESHOLD=4; four retires pc_current=pc_next=0x40 -> halt high after 4th, status read = 0x0010_0003 with 4 entries? no: status = {count=4}<<16 | 0x03 = 0x0004_0003.
REQ-039 INSTRUCTION_LIMIT=10, distinct PCs -> halt after 10th retire, cause 2, retire_count read 10; 11th retire not counted.
REQ-040 TRACE_DEPTH=4; 6 retires PCs 0x0,0x4..0x14 -> status full=1, overflow=1; address 2 read returns 0x8.
REQ-041 ALLOW_ILLEGAL_INSTRUCTIONS=0; retire instruction 0x0000007F in same cycle loop threshold reached -> cause 3.
REQ-042 Halted state, write address 0 with retire -> halt low next cycle, retire_count unchanged, FIFO unchanged.
REQ-043 reset asserted while halted with 3 entries -> next cycle halt 0, status read = 0x0000_0010.
